// File: rtl/prog_loader_if.sv
// Config byte stream into the bitstream loader.
// Source drives data/valid, loader returns ready.
interface prog_loader_if;
  logic [7:0] cfg_data;
  logic       cfg_valid;
  logic       cfg_ready;

  modport master (
    output cfg_data,
    output cfg_valid,
    input  cfg_ready
  );

  modport slave (
    input  cfg_data,
    input  cfg_valid,
    output cfg_ready
  );
endinterface

// File: rtl/prog_loader.sv
// Serialises config bytes MSB-first into the prog scan chain,
// then recirculates the chain once and compares CRC-8 values.
module prog_loader #(
  parameter int CHAIN_LEN = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  prog_loader_if.slave cfg,
  input  logic         chain_out,
  output logic         prog_en,
  output logic         prog_in,
  output logic         busy,
  output logic         done,
  output logic         err
);
  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam logic [CNT_W-1:0] LEN  = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

  typedef enum logic [1:0] {
    IDLE, LOAD, VERIFY, DONE
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       byte_q, byte_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] req_q, req_d;
  logic [CNT_W-1:0] shf_q, shf_d;
  logic [7:0]       crcl_q, crcl_d;
  logic [7:0]       crcc_q, crcc_d;
  logic             err_q, err_d;
  logic             ready;
  logic             shift;

  function automatic logic [7:0] crc8(
    input logic [7:0] c,
    input logic       b
  );
    return {c[6:0], 1'b0} ^ ((c[7] ^ b) ? 8'h07 : 8'h00);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      byte_q  <= '0;
      cnt_q   <= '0;
      req_q   <= '0;
      shf_q   <= '0;
      crcl_q  <= '0;
      crcc_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      shf_q   <= shf_d;
      crcl_q  <= crcl_d;
      crcc_q  <= crcc_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    shf_d   = shf_q;
    crcl_d  = crcl_q;
    crcc_d  = crcc_q;
    err_d   = err_q;
    ready   = 1'b0;
    shift   = 1'b0;
    prog_en = 1'b0;
    prog_in = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (abort) begin
          state_d = IDLE;
          err_d   = 1'b0;
        end else if (start) begin
          state_d = LOAD;
          byte_d  = '0;
          cnt_d   = '0;
          req_d   = '0;
          shf_d   = '0;
          crcl_d  = '0;
          crcc_d  = '0;
          err_d   = 1'b0;
        end
      end
      LOAD: begin
        ready   = (cnt_q <= 4'd1) && (req_q < LEN);
        shift   = (cnt_q != 4'd0);
        prog_en = shift;
        prog_in = byte_q[7];
        if (abort) begin
          state_d = IDLE;
        end else begin
          if (shift) begin
            byte_d = {byte_q[6:0], 1'b0};
            cnt_d  = cnt_q - 4'd1;
            shf_d  = shf_q + 1'b1;
            crcl_d = crc8(crcl_q, byte_q[7]);
          end
          // reload on the last-bit cycle keeps the stream bubble-free
          if (cfg.cfg_valid && ready) begin
            byte_d = cfg.cfg_data;
            cnt_d  = 4'd8;
            if (int'(req_q) + 8 >= CHAIN_LEN)
              req_d = LEN;
            else
              req_d = req_q + CNT_W'(8);
          end
          if (shift && shf_q == LAST) begin
            state_d = VERIFY;
            byte_d  = '0;
            cnt_d   = '0;
            shf_d   = '0;
          end
        end
      end
      VERIFY: begin
        prog_en = 1'b1;
        prog_in = chain_out;
        if (abort) begin
          state_d = IDLE;
        end else begin
          crcc_d = crc8(crcc_q, chain_out);
          shf_d  = shf_q + 1'b1;
          if (shf_q == LAST) begin
            state_d = DONE;
            shf_d   = '0;
            err_d   = (crcc_d != crcl_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cfg.cfg_ready = ready;
  assign busy = (state_q == LOAD) || (state_q == VERIFY);
  assign done = (state_q == DONE);
  assign err  = done && err_q;
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench: 16-bit and 12-bit chain models around two loaders,
// checking shifted bit streams, stalls, faults, truncation and abort.
module tb_prog_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start16 = 1'b0;
  logic start12 = 1'b0;
  logic abort = 1'b0;
  logic vld = 1'b0;
  logic [7:0] dat = 8'h00;
  logic flip = 1'b0;

  logic en16, pin16, busy16, done16, err16;
  logic en12, pin12, busy12, done12, err12;
  logic [15:0] ch16 = '0;
  logic [11:0] ch12 = '0;

  int n_chk = 0;
  int n_fail = 0;

  prog_loader_if if16 ();
  prog_loader_if if12 ();

  assign if16.cfg_valid = vld;
  assign if16.cfg_data  = dat;
  assign if12.cfg_valid = vld;
  assign if12.cfg_data  = dat;

  prog_loader #(.CHAIN_LEN(16)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start16),
    .abort     (abort),
    .cfg       (if16.slave),
    .chain_out (ch16[15]),
    .prog_en   (en16),
    .prog_in   (pin16),
    .busy      (busy16),
    .done      (done16),
    .err       (err16)
  );

  prog_loader #(.CHAIN_LEN(12)) dut12 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start12),
    .abort     (abort),
    .cfg       (if12.slave),
    .chain_out (ch12[11]),
    .prog_en   (en12),
    .prog_in   (pin12),
    .busy      (busy12),
    .done      (done12),
    .err       (err12)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (en16)
      ch16 <= {ch16[14:0], pin16} ^ (flip ? 16'h0100 : 16'h0000);
    if (en12)
      ch12 <= {ch12[10:0], pin12};
  end

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_load(
    input  bit          u12,
    input  logic [7:0]  b0,
    input  logic [7:0]  b1,
    input  logic [7:0]  b2,
    input  int          stall,
    input  int          abort_at,
    input  bit          fault,
    output logic [31:0] seq,
    output int          nen,
    output int          gaps,
    output int          nacc,
    output int          late_rdy,
    output bit          fin
  );
    logic [7:0] bytes [3];
    int idx, srem, len;
    logic rdy, en, pin, bsy, dn;
    bytes[0] = b0;
    bytes[1] = b1;
    bytes[2] = b2;
    idx = 0;
    srem = stall;
    len = u12 ? 12 : 16;
    seq = '0;
    nen = 0;
    gaps = 0;
    nacc = 0;
    late_rdy = 0;
    fin = 1'b0;
    @(negedge clk);
    if (u12) start12 = 1'b1;
    else start16 = 1'b1;
    @(negedge clk);
    start12 = 1'b0;
    start16 = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      rdy = u12 ? if12.cfg_ready : if16.cfg_ready;
      en  = u12 ? en12 : en16;
      pin = u12 ? pin12 : pin16;
      bsy = u12 ? busy12 : busy16;
      dn  = u12 ? done12 : done16;
      if (dn) begin
        fin = 1'b1;
        break;
      end
      vld = 1'b0;
      if (idx < 3) begin
        if (idx == 1 && rdy && srem > 0) begin
          srem--;
        end else begin
          vld = 1'b1;
          dat = bytes[idx];
        end
      end
      if (idx >= 2 && rdy) late_rdy++;
      if (vld && rdy) begin
        idx++;
        nacc++;
      end
      if (en) begin
        seq = {seq[30:0], pin};
        nen++;
      end else if (bsy && nen > 0) begin
        gaps++;
      end
      flip = fault && en && nen == len + 1;
      if (abort_at > 0 && nen == abort_at) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        vld = 1'b0;
        return;
      end
      @(negedge clk);
    end
    vld = 1'b0;
    flip = 1'b0;
  endtask

  initial begin
    logic [31:0] seq;
    int nen, gaps, nacc, late;
    bit fin;

    // reset held with start asserted
    rst_n = 1'b0;
    start16 = 1'b1;
    start12 = 1'b1;
    repeat (2) @(negedge clk);
    check("rst prog_en", en16, 0);
    check("rst prog_in", pin16, 0);
    check("rst busy", busy16, 0);
    check("rst done", done16, 0);
    check("rst err", err16, 0);
    check("rst cfg_ready", if16.cfg_ready, 0);
    check("rst busy12", busy12, 0);
    rst_n = 1'b1;
    start16 = 1'b0;
    start12 = 1'b0;
    @(negedge clk);
    check("idle busy", busy16, 0);
    check("idle cfg_ready", if16.cfg_ready, 0);

    // back-to-back load
    do_load(0, 8'hA5, 8'h3C, 8'h77, 0, 0, 0,
            seq, nen, gaps, nacc, late, fin);
    check("b2b fin", fin, 1);
    check("b2b seq", seq, 32'hA53C_A53C);
    check("b2b nen", nen, 32);
    check("b2b gaps", gaps, 0);
    check("b2b nacc", nacc, 2);
    check("b2b err", err16, 0);
    check("b2b busy", busy16, 0);
    check("b2b chain", ch16, 16'hA53C);
    @(negedge clk);
    check("b2b done held", done16, 1);

    // stall between bytes, restarted from DONE
    do_load(0, 8'hA5, 8'h3C, 8'h77, 3, 0, 0,
            seq, nen, gaps, nacc, late, fin);
    check("stall fin", fin, 1);
    check("stall seq", seq, 32'hA53C_A53C);
    check("stall gaps", gaps, 3);
    check("stall nen", nen, 32);
    check("stall err", err16, 0);
    check("stall chain", ch16, 16'hA53C);

    // single chain bit flipped during recirculation
    do_load(0, 8'h12, 8'h34, 8'h00, 0, 0, 1,
            seq, nen, gaps, nacc, late, fin);
    check("fault fin", fin, 1);
    check("fault done", done16, 1);
    check("fault err", err16, 1);

    // abort mid-load, then clean reload
    do_load(0, 8'hA5, 8'h3C, 8'h00, 0, 5, 0,
            seq, nen, gaps, nacc, late, fin);
    check("abort prog_en", en16, 0);
    check("abort busy", busy16, 0);
    check("abort done", done16, 0);
    check("abort err", err16, 0);
    check("abort seq", seq[4:0], 5'b10100);
    do_load(0, 8'h5A, 8'hC3, 8'h11, 0, 0, 0,
            seq, nen, gaps, nacc, late, fin);
    check("reload fin", fin, 1);
    check("reload seq", seq, 32'h5AC3_5AC3);
    check("reload err", err16, 0);
    check("reload chain", ch16, 16'h5AC3);

    // truncation on the 12-bit chain
    do_load(1, 8'hFF, 8'h0F, 8'hAA, 0, 0, 0,
            seq, nen, gaps, nacc, late, fin);
    check("trunc fin", fin, 1);
    check("trunc seq", seq[23:0], 24'hFF0_FF0);
    check("trunc nen", nen, 24);
    check("trunc nacc", nacc, 2);
    check("trunc late_rdy", late, 0);
    check("trunc err", err12, 0);
    check("trunc chain", ch12, 12'hFF0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
